// File: rtl/jtag_pkg.sv
// Shared JTAG TAP types: state encoding, reset state and IR-column helper.
package jtag_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR = 4'h0,
    EXIT1_DR = 4'h1,
    SHIFT_DR = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EXIT2_IR = 4'h8,
    EXIT1_IR = 4'h9,
    SHIFT_IR = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_t;

  localparam tap_state_t TAP_RESET_STATE = TLR;

  function automatic logic is_ir_state(input tap_state_t s);
    return (s inside {SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR});
  endfunction

endpackage

// File: rtl/tap_controller_if.sv
// TAP control bundle: TMS in, decoded state and strobes out to the IR/DR cells.
interface tap_controller_if;
  import jtag_pkg::*;

  logic       tms;
  tap_state_t state;
  logic       reset_n;
  logic       clock_ir;
  logic       shift_ir;
  logic       update_ir;
  logic       clock_dr;
  logic       shift_dr;
  logic       update_dr;
  logic       select;
  logic       tdo_en;

  modport master (
    output tms,
    input  state, reset_n, clock_ir, shift_ir, update_ir,
    input  clock_dr, shift_dr, update_dr, select, tdo_en
  );

  modport slave (
    input  tms,
    output state, reset_n, clock_ir, shift_ir, update_ir,
    output clock_dr, shift_dr, update_dr, select, tdo_en
  );
endinterface

// File: rtl/tap_output_decode.sv
// Moore decode of the TAP state into IR/DR strobes; purely combinational.
module tap_output_decode
  import jtag_pkg::*;
(
  input  tap_state_t state,
  output logic       reset_n,
  output logic       clock_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       clock_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       select,
  output logic       tdo_en
);

  assign reset_n   = (state != TLR);
  assign clock_ir  = (state == CAP_IR) || (state == SHIFT_IR);
  assign shift_ir  = (state == SHIFT_IR);
  assign update_ir = (state == UPD_IR);
  assign clock_dr  = (state == CAP_DR) || (state == SHIFT_DR);
  assign shift_dr  = (state == SHIFT_DR);
  assign update_dr = (state == UPD_DR);
  assign select    = is_ir_state(state);
  assign tdo_en    = shift_ir | shift_dr;

endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP state machine; optional Run-Test/Idle counter under JTAG_IDLE_CNT_EN.
module tap_controller
  import jtag_pkg::*;
#(
  parameter int idle_cnt_width = 16
) (
  input  logic                      tck,
  input  logic                      trst_n,
  tap_controller_if.slave           tap
`ifdef JTAG_IDLE_CNT_EN
  ,
  output logic [idle_cnt_width-1:0] idle_cnt
`endif
);

  tap_state_t state_q, state_d;

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) state_q <= TAP_RESET_STATE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = TAP_RESET_STATE;
    case (state_q)
      TLR:      state_d = tap.tms ? TLR      : RTI;
      RTI:      state_d = tap.tms ? SEL_DR   : RTI;
      SEL_DR:   state_d = tap.tms ? SEL_IR   : CAP_DR;
      CAP_DR:   state_d = tap.tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: state_d = tap.tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: state_d = tap.tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_d = tap.tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: state_d = tap.tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   state_d = tap.tms ? SEL_DR   : RTI;
      SEL_IR:   state_d = tap.tms ? TLR      : CAP_IR;
      CAP_IR:   state_d = tap.tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: state_d = tap.tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: state_d = tap.tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_d = tap.tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: state_d = tap.tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   state_d = tap.tms ? SEL_DR   : RTI;
      default:  state_d = TAP_RESET_STATE;
    endcase
  end

`ifdef JTAG_IDLE_CNT_EN
  localparam logic [idle_cnt_width-1:0] CNT_ONE = {{(idle_cnt_width-1){1'b0}}, 1'b1};

  logic [idle_cnt_width-1:0] idle_q;

  // Entering RTI restarts the count; staying in RTI counts up to all-ones and sticks.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      idle_q <= '0;
    end else if (state_d == RTI) begin
      if (state_q != RTI)  idle_q <= '0;
      else if (idle_q != '1) idle_q <= idle_q + CNT_ONE;
    end
  end

  assign idle_cnt = idle_q;
`endif

  logic reset_n_w, clock_ir_w, shift_ir_w, update_ir_w;
  logic clock_dr_w, shift_dr_w, update_dr_w, select_w, tdo_en_w;

  tap_output_decode u_decode (
    .state     (state_q),
    .reset_n   (reset_n_w),
    .clock_ir  (clock_ir_w),
    .shift_ir  (shift_ir_w),
    .update_ir (update_ir_w),
    .clock_dr  (clock_dr_w),
    .shift_dr  (shift_dr_w),
    .update_dr (update_dr_w),
    .select    (select_w),
    .tdo_en    (tdo_en_w)
  );

  assign tap.state     = state_q;
  assign tap.reset_n   = reset_n_w;
  assign tap.clock_ir  = clock_ir_w;
  assign tap.shift_ir  = shift_ir_w;
  assign tap.update_ir = update_ir_w;
  assign tap.clock_dr  = clock_dr_w;
  assign tap.shift_dr  = shift_dr_w;
  assign tap.update_dr = update_dr_w;
  assign tap.select    = select_w;
  assign tap.tdo_en    = tdo_en_w;

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller; idle counter scenario only with JTAG_IDLE_CNT_EN.
module tb_tap_controller;

  logic tck = 1'b0;
  logic trst_n = 1'b0;
  always #5 tck = ~tck;

  tap_controller_if tap_bus();

`ifdef JTAG_IDLE_CNT_EN
  logic [3:0] idle_cnt;
  tap_controller #(.idle_cnt_width(4)) dut (
    .tck(tck), .trst_n(trst_n), .tap(tap_bus), .idle_cnt(idle_cnt)
  );
`else
  tap_controller dut (
    .tck(tck), .trst_n(trst_n), .tap(tap_bus)
  );
`endif

  int total = 0;
  int bad = 0;

  // Reference model: transition table straight from the state diagram.
  logic [3:0] nx0 [16];
  logic [3:0] nx1 [16];
  string      path_from_tlr [16];
  logic [3:0] m_state;
  int         m_idle;

  task automatic init_model();
    nx0[4'hF] = 4'hC; nx1[4'hF] = 4'hF;
    nx0[4'hC] = 4'hC; nx1[4'hC] = 4'h7;
    nx0[4'h7] = 4'h6; nx1[4'h7] = 4'h4;
    nx0[4'h6] = 4'h2; nx1[4'h6] = 4'h1;
    nx0[4'h2] = 4'h2; nx1[4'h2] = 4'h1;
    nx0[4'h1] = 4'h3; nx1[4'h1] = 4'h5;
    nx0[4'h3] = 4'h3; nx1[4'h3] = 4'h0;
    nx0[4'h0] = 4'h2; nx1[4'h0] = 4'h5;
    nx0[4'h5] = 4'hC; nx1[4'h5] = 4'h7;
    nx0[4'h4] = 4'hE; nx1[4'h4] = 4'hF;
    nx0[4'hE] = 4'hA; nx1[4'hE] = 4'h9;
    nx0[4'hA] = 4'hA; nx1[4'hA] = 4'h9;
    nx0[4'h9] = 4'hB; nx1[4'h9] = 4'hD;
    nx0[4'hB] = 4'hB; nx1[4'hB] = 4'h8;
    nx0[4'h8] = 4'hA; nx1[4'h8] = 4'hD;
    nx0[4'hD] = 4'hC; nx1[4'hD] = 4'h7;
    path_from_tlr[4'hF] = "";
    path_from_tlr[4'hC] = "0";
    path_from_tlr[4'h7] = "01";
    path_from_tlr[4'h6] = "010";
    path_from_tlr[4'h2] = "0100";
    path_from_tlr[4'h1] = "0101";
    path_from_tlr[4'h3] = "01010";
    path_from_tlr[4'h0] = "010101";
    path_from_tlr[4'h5] = "01011";
    path_from_tlr[4'h4] = "011";
    path_from_tlr[4'hE] = "0110";
    path_from_tlr[4'hA] = "01100";
    path_from_tlr[4'h9] = "01101";
    path_from_tlr[4'hB] = "011010";
    path_from_tlr[4'h8] = "0110101";
    path_from_tlr[4'hD] = "011011";
  endtask

  // {reset_n, clock_ir, shift_ir, update_ir, clock_dr, shift_dr, update_dr, select, tdo_en}
  function automatic logic [8:0] exp_out(input logic [3:0] s);
    logic ir_col;
    ir_col = (s == 4'h4) || (s == 4'hE) || (s == 4'hA) || (s == 4'h9) ||
             (s == 4'hB) || (s == 4'h8) || (s == 4'hD);
    return {s != 4'hF, (s == 4'hE) || (s == 4'hA), s == 4'hA, s == 4'hD,
            (s == 4'h6) || (s == 4'h2), s == 4'h2, s == 4'h5, ir_col,
            (s == 4'hA) || (s == 4'h2)};
  endfunction

  function automatic logic [8:0] act_out();
    return {tap_bus.reset_n, tap_bus.clock_ir, tap_bus.shift_ir, tap_bus.update_ir,
            tap_bus.clock_dr, tap_bus.shift_dr, tap_bus.update_dr, tap_bus.select,
            tap_bus.tdo_en};
  endfunction

  // Drive tms, take one rising edge, advance the model, land 1 time unit after the edge.
  task automatic step(input bit t);
    logic [3:0] prev;
    tap_bus.tms = t;
    @(posedge tck);
    #1;
    prev = m_state;
    m_state = t ? nx1[prev] : nx0[prev];
    if (m_state == 4'hC) begin
      if (prev != 4'hC) m_idle = 0;
      else if (m_idle < 15) m_idle = m_idle + 1;
    end
  endtask

  task automatic go_tlr();
    for (int i = 0; i < 5; i++) step(1'b1);
  endtask

  task automatic go_state(input logic [3:0] s);
    string p;
    go_tlr();
    p = path_from_tlr[s];
    for (int k = 0; k < p.len(); k++) step(p[k] == "1");
  endtask

  task automatic pulse_async_reset();
    #2 trst_n = 1'b0;
    #1;
    m_state = 4'hF;
    m_idle  = 0;
  endtask

  task automatic test_reset();
    total++;
    if (tap_bus.state !== 4'hF) begin
      bad++; $display("FAIL reset_state: got %h want f", tap_bus.state);
    end
    total++;
    if (act_out() !== 9'b0) begin
      bad++; $display("FAIL reset_outputs: got %b want %b", act_out(), 9'b0);
    end
`ifdef JTAG_IDLE_CNT_EN
    total++;
    if (idle_cnt !== 4'd0) begin
      bad++; $display("FAIL reset_idle: got %0d want 0", idle_cnt);
    end
`endif
    trst_n = 1'b1;
    step(1'b0);
    total++;
    if (tap_bus.state !== 4'hC) begin
      bad++; $display("FAIL release_to_rti: got %h want c", tap_bus.state);
    end
    step(1'b1); step(1'b0); step(1'b0);
    total++;
    if (tap_bus.state !== 4'h2) begin
      bad++; $display("FAIL reach_shift_dr: got %h want 2", tap_bus.state);
    end
    pulse_async_reset();
    total++;
    if (tap_bus.state !== 4'hF || tap_bus.reset_n !== 1'b0) begin
      bad++; $display("FAIL async_mid_shift: got state=%h reset_n=%b want f/0",
                      tap_bus.state, tap_bus.reset_n);
    end
    tap_bus.tms = 1'b0;
    @(posedge tck);
    #1;
    total++;
    if (tap_bus.state !== 4'hF) begin
      bad++; $display("FAIL trst_dominates_tms: got %h want f", tap_bus.state);
    end
    trst_n = 1'b1;
    step(1'b0);
    total++;
    if (tap_bus.state !== 4'hC) begin
      bad++; $display("FAIL release_after_mid_shift: got %h want c", tap_bus.state);
    end
  endtask

  task automatic test_ir_scan();
    step(1'b1); step(1'b1); step(1'b0);
    total++;
    if (tap_bus.state !== 4'hE || tap_bus.clock_ir !== 1'b1 || tap_bus.shift_ir !== 1'b0) begin
      bad++; $display("FAIL capture_ir: got state=%h clk=%b sh=%b want e/1/0",
                      tap_bus.state, tap_bus.clock_ir, tap_bus.shift_ir);
    end
    step(1'b0);
    total++;
    if (tap_bus.state !== 4'hA || {tap_bus.clock_ir, tap_bus.shift_ir, tap_bus.tdo_en,
        tap_bus.select} !== 4'b1111) begin
      bad++; $display("FAIL shift_ir: got state=%h outs=%b want a/%b", tap_bus.state,
                      act_out(), exp_out(4'hA));
    end
    for (int i = 0; i < 4; i++) step(1'b0);
    total++;
    if (tap_bus.state !== 4'hA) begin
      bad++; $display("FAIL shift_ir_hold: got %h want a", tap_bus.state);
    end
    step(1'b1);
    total++;
    if (tap_bus.state !== 4'h9 || tap_bus.update_ir !== 1'b0) begin
      bad++; $display("FAIL exit1_ir: got state=%h upd=%b want 9/0",
                      tap_bus.state, tap_bus.update_ir);
    end
    step(1'b1);
    total++;
    if (tap_bus.state !== 4'hD || tap_bus.update_ir !== 1'b1) begin
      bad++; $display("FAIL update_ir: got state=%h upd=%b want d/1",
                      tap_bus.state, tap_bus.update_ir);
    end
    step(1'b0);
    total++;
    if (tap_bus.state !== 4'hC || tap_bus.update_ir !== 1'b0) begin
      bad++; $display("FAIL update_ir_one_cycle: got state=%h upd=%b want c/0",
                      tap_bus.state, tap_bus.update_ir);
    end
  endtask

  task automatic test_dr_pause();
    bit         seq  [9] = '{1, 0, 0, 1, 0, 1, 0, 1, 1};
    logic [3:0] want [9] = '{4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0, 4'h2, 4'h1, 4'h5};
    for (int i = 0; i < 9; i++) begin
      step(seq[i]);
      total++;
      if (tap_bus.state !== want[i] || act_out() !== exp_out(want[i])) begin
        bad++; $display("FAIL dr_pause_step%0d: got state=%h outs=%b want %h/%b", i,
                        tap_bus.state, act_out(), want[i], exp_out(want[i]));
      end
    end
    total++;
    if (tap_bus.update_dr !== 1'b1) begin
      bad++; $display("FAIL update_dr: got %b want 1", tap_bus.update_dr);
    end
    step(1'b0);
  endtask

  task automatic test_escape();
    for (int s = 0; s < 16; s++) begin
      go_state(4'(s));
      total++;
      if (tap_bus.state !== 4'(s)) begin
        bad++; $display("FAIL escape_reach_%h: got %h want %h", s, tap_bus.state, 4'(s));
      end
      go_tlr();
      total++;
      if (tap_bus.state !== 4'hF) begin
        bad++; $display("FAIL escape_from_%h: got %h want f", s, tap_bus.state);
      end
    end
    go_state(4'hA);
    for (int i = 0; i < 4; i++) step(1'b1);
    total++;
    if (tap_bus.state !== 4'h4) begin
      bad++; $display("FAIL four_ones_from_shift_ir: got %h want 4", tap_bus.state);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        pulse_async_reset();
        total++;
        if (tap_bus.state !== 4'hF || act_out() !== 9'b0) begin
          bad++; $display("FAIL rand_async_reset%0d: got %h/%b want f/0", n,
                          tap_bus.state, act_out());
        end
        @(posedge tck);
        #1;
        trst_n = 1'b1;
      end
      step($urandom_range(0, 9) < 4);
      total++;
      if (tap_bus.state !== m_state || act_out() !== exp_out(m_state)) begin
        bad++; $display("FAIL rand_step%0d: got %h/%b want %h/%b", n, tap_bus.state,
                        act_out(), m_state, exp_out(m_state));
      end
`ifdef JTAG_IDLE_CNT_EN
      total++;
      if (int'(idle_cnt) != m_idle) begin
        bad++; $display("FAIL rand_idle%0d: got %0d want %0d", n, idle_cnt, m_idle);
      end
`endif
    end
  endtask

`ifdef JTAG_IDLE_CNT_EN
  task automatic test_idle_cnt();
    go_tlr();
    step(1'b0);
    total++;
    if (idle_cnt !== 4'd0) begin
      bad++; $display("FAIL idle_entry: got %0d want 0", idle_cnt);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      total++;
      if (int'(idle_cnt) != ((i + 1 > 15) ? 15 : i + 1)) begin
        bad++; $display("FAIL idle_count%0d: got %0d want %0d", i, idle_cnt,
                        (i + 1 > 15) ? 15 : i + 1);
      end
    end
    step(1'b1);
    total++;
    if (idle_cnt !== 4'd15) begin
      bad++; $display("FAIL idle_hold: got %0d want 15", idle_cnt);
    end
    step(1'b1); step(1'b1); step(1'b0);
    total++;
    if (tap_bus.state !== 4'hC || idle_cnt !== 4'd0) begin
      bad++; $display("FAIL idle_reentry: got %h/%0d want c/0", tap_bus.state, idle_cnt);
    end
  endtask
`endif

  initial begin
    init_model();
    m_state = 4'hF;
    m_idle  = 0;
    tap_bus.tms = 1'b1;
    trst_n = 1'b0;
    repeat (2) @(posedge tck);
    #1;
    test_reset();
    test_ir_scan();
    test_dr_pause();
    test_escape();
`ifdef JTAG_IDLE_CNT_EN
    test_idle_cnt();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tap_controller.md
Name: tap_controller

Overview:
- IEEE 1149.1 TAP state machine for the JTAG block.
- Sits directly upstream of the instruction register and the data-register chain.
- Samples TMS on each rising TCK and advances the 16-state TAP FSM.
- Decodes the state into the capture/shift/update strobes, test-logic reset, IR/DR select and TDO enable that the IR and DR cells consume.

Parameters:
- idle_cnt_width, 16, width of the Run-Test/Idle cycle counter. Used only when JTAG_IDLE_CNT_EN is defined.

Ports:
- tck  input  1  test clock; single clock, all state changes on its rising edge.
- trst_n  input  1  test reset; asynchronous, active-low; forces Test-Logic-Reset.
- tms  input  1  test mode select, sampled on rising tck.
- state  output  4  current TAP state, tap_state_t encoding.
- reset_n  output  1  low while in Test-Logic-Reset; drives IR/DR update cells.
- clock_ir  output  1  IR cell clock-enable; high in Capture-IR and Shift-IR.
- shift_ir  output  1  high in Shift-IR; selects serial input over parallel capture.
- update_ir  output  1  high in Update-IR.
- clock_dr  output  1  high in Capture-DR and Shift-DR.
- shift_dr  output  1  high in Shift-DR.
- update_dr  output  1  high in Update-DR.
- select  output  1  high in every IR-column state (Select-IR-Scan through Update-IR); steers the TDO mux to IR.
- tdo_en  output  1  shift_ir | shift_dr.
- idle_cnt  output  idle_cnt_width  present only with JTAG_IDLE_CNT_EN.

Behaviour:
- **State register:** 4-bit, tap_state_t encoding.
  - TLR=F, RTI=C, SEL_DR=7, CAP_DR=6, SHIFT_DR=2, EXIT1_DR=1, PAUSE_DR=3, EXIT2_DR=0, UPD_DR=5.
  - SEL_IR=4, CAP_IR=E, SHIFT_IR=A, EXIT1_IR=9, PAUSE_IR=B, EXIT2_IR=8, UPD_IR=D.
- **Transitions (tms=0 / tms=1):**
  - TLR: RTI / TLR
  - RTI: RTI / SEL_DR
  - SEL_DR: CAP_DR / SEL_IR
  - CAP_DR: SHIFT_DR / EXIT1_DR
  - SHIFT_DR: SHIFT_DR / EXIT1_DR
  - EXIT1_DR: PAUSE_DR / UPD_DR
  - PAUSE_DR: PAUSE_DR / EXIT2_DR
  - EXIT2_DR: SHIFT_DR / UPD_DR
  - UPD_DR: RTI / SEL_DR
  - SEL_IR: CAP_IR / TLR
  - IR column mirrors the DR column with IR states; UPD_IR: RTI / SEL_DR.
- **Reset:**
  - trst_n low asynchronously forces state=TLR regardless of tck, including mid-shift.
  - Release is synchronous to the next rising tck; the first transition uses the tms value sampled at that edge.
- **Outputs:**
  - All strobes are Moore outputs decoded combinationally from the state register.
  - Latency: strobe valid in the same cycle the state is entered. No output depends on tms combinationally.
- **Reset values (trst_n low):**
  - state=F, reset_n=0.
  - clock_ir, shift_ir, update_ir, clock_dr, shift_dr, update_dr, select, tdo_en all 0.
  - idle_cnt=0.
- **Capture vs shift:** the IR/DR cells capture when clock_x=1 and shift_x=0, and shift when both are 1.
- **Update strobes:** update_ir and update_dr are high for exactly one tck per pass through the update state.
- **Synchronous escape:** five consecutive rising edges with tms=1 reach TLR from any state.
- **Illegal encodings:** none are reachable. The default branch goes to TLR.
- **Simultaneous events:** trst_n low dominates any tms value.

Optional Feature:
- Macro: JTAG_IDLE_CNT_EN.
- With the macro:
  - idle_cnt port exists.
  - Counter clears to 0 on entry to RTI and increments each tck spent in RTI.
  - Saturates at 2^idle_cnt_width-1; no wrap.
  - Holds its value outside RTI.
  - Asynchronously cleared by trst_n.
- Without the macro: port and counter logic are absent; FSM behaviour is identical.

Decomposition:
- jtag_pkg holds:
  - tap_state_t, the 4-bit enum with the encodings above.
  - TAP_RESET_STATE constant.
  - is_ir_state() helper function.
- One sub-module is natural: tap_output_decode, a combinational state-to-strobe decode. The FSM register and the idle counter stay in tap_controller.

Test Plan:
- trst_n=0 in SHIFT_DR, asserted mid-cycle → state=F and reset_n=0 immediately. After release with tms=0, next edge → state=C.
- From RTI, drive tms 1,1,0,0 → SEL_DR, SEL_IR, CAP_IR (clock_ir=1, shift_ir=0), SHIFT_IR (clock_ir=1, shift_ir=1, tdo_en=1, select=1).
- In SHIFT_IR, tms=0 for 4 cycles then tms 1,1 → EXIT1_IR, then UPD_IR with update_ir=1 for exactly 1 cycle. Next edge with tms=0 → RTI.
- DR pause path, tms sequence 1,0,0,1,0,1,0,1,1 from RTI → SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, SHIFT_DR, EXIT1_DR, UPD_DR (update_dr=1).
- From each of the 16 states, tms=1 for 5 edges → state=F. Also check that 4 edges from SHIFT_IR reach SEL_IR, not TLR.
- With JTAG_IDLE_CNT_EN and idle_cnt_width=4, hold tms=0 in RTI for 20 edges → idle_cnt reads 15 (saturated). Leave and re-enter RTI → idle_cnt=0.
